boost_shadow_tracker: RTL and testbench

//  Per-register state for the boosted/sequential register-copy pairs: one SeqPtr bit
//  and one BoostValid bit per architectural register.

---
 rtl/boost_shadow_tracker.sv | 100 ++++++++++
 tb/tb_boost_shadow_tracker.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/boost_shadow_tracker.sv
// Boosted/sequential register-copy tracker: one SeqPtr and one BoostValid bit per
// architectural register, flipped on commit and discarded on squash or exception.

module boost_shadow_cell (
    input  logic Phi1,
    input  logic Reset_b,
    input  logic sq,
    input  logic cm,
    input  logic bw,
    output logic seqPtr,
    output logic boostValid,
    output logic nextValid
);
    // Squash and commit both empty the boosted copy; otherwise a boosted write fills it.
    assign nextValid = ~sq & ~cm & (boostValid | bw);

    always_ff @(posedge Phi1 or negedge Reset_b) begin
        if (!Reset_b) begin
            seqPtr     <= 1'b0;
            boostValid <= 1'b0;
        end else begin
            boostValid <= nextValid;
            if (cm)
                seqPtr <= seqPtr ^ (boostValid | bw);
        end
    end
endmodule

module boost_shadow_tracker #(
    parameter int NREGS = 32,
    parameter int RIDX  = 5
) (
    input  logic            Phi1,
    input  logic            Reset_b,
    input  logic            Stall_s1,
    input  logic            Except_s1w,
    input  logic            Commit_s1e,
    input  logic            Squash_s1e,
    input  logic            AWrValid_w,
    input  logic            ABoost_w,
    input  logic [RIDX-1:0] AWrIdx_w,
    input  logic            BWrValid_w,
    input  logic            BBoost_w,
    input  logic [RIDX-1:0] BWrIdx_w,
    output logic            ASeqPtr_v1e,
    output logic            BSeqPtr_v1e,
    input  logic [RIDX-1:0] RdIdx0_r,
    input  logic [RIDX-1:0] RdIdx1_r,
    input  logic            RdBoost0_r,
    input  logic            RdBoost1_r,
    output logic            RdSel0_r,
    output logic            RdSel1_r,
    output logic [RIDX:0]   BoostCnt,
    output logic            BoostAny
);
    logic [NREGS-1:0] seqPtr, boostValid, nextValid, bw;
    logic [RIDX:0]    nextCnt;
    logic             sq, cm;

    // Exception overrides stall; squash beats commit.
    assign sq = (Squash_s1e & ~Stall_s1) | Except_s1w;
    assign cm = Commit_s1e & ~Stall_s1 & ~sq;

    for (genvar r = 0; r < NREGS; r++) begin : gReg
        assign bw[r] = (AWrValid_w & ABoost_w & (AWrIdx_w == RIDX'(r))) |
                       (BWrValid_w & BBoost_w & (BWrIdx_w == RIDX'(r)));

        boost_shadow_cell uCell (
            .Phi1       (Phi1),
            .Reset_b    (Reset_b),
            .sq         (sq),
            .cm         (cm),
            .bw         (bw[r]),
            .seqPtr     (seqPtr[r]),
            .boostValid (boostValid[r]),
            .nextValid  (nextValid[r])
        );
    end

    assign ASeqPtr_v1e = seqPtr[AWrIdx_w];
    assign BSeqPtr_v1e = seqPtr[BWrIdx_w];
    // Same-cycle boosted writes are deliberately not forwarded to the read selects.
    assign RdSel0_r = seqPtr[RdIdx0_r] ^ (RdBoost0_r & boostValid[RdIdx0_r]);
    assign RdSel1_r = seqPtr[RdIdx1_r] ^ (RdBoost1_r & boostValid[RdIdx1_r]);

    always_comb begin
        nextCnt = '0;
        for (int i = 0; i < NREGS; i++)
            nextCnt = nextCnt + {{RIDX{1'b0}}, nextValid[i]};
    end

    always_ff @(posedge Phi1 or negedge Reset_b) begin
        if (!Reset_b)
            BoostCnt <= '0;
        else
            BoostCnt <= nextCnt;
    end

    assign BoostAny = |BoostCnt;
endmodule

// File: tb/tb_boost_shadow_tracker.sv
// Self-checking bench for boost_shadow_tracker: directed vector table, corner sequences,
// and randomized traffic against a per-register reference model.

module tb_boost_shadow_tracker;
    localparam int NREGS = 32;
    localparam int RIDX  = 5;

    logic Phi1 = 1'b0;
    logic Reset_b;
    logic Stall_s1, Except_s1w, Commit_s1e, Squash_s1e;
    logic AWrValid_w, ABoost_w, BWrValid_w, BBoost_w;
    logic [RIDX-1:0] AWrIdx_w, BWrIdx_w, RdIdx0_r, RdIdx1_r;
    logic RdBoost0_r, RdBoost1_r;
    logic ASeqPtr_v1e, BSeqPtr_v1e, RdSel0_r, RdSel1_r, BoostAny;
    logic [RIDX:0] BoostCnt;

    always #5 Phi1 = ~Phi1;

    boost_shadow_tracker #(.NREGS(NREGS), .RIDX(RIDX)) dut (
        .Phi1(Phi1), .Reset_b(Reset_b), .Stall_s1(Stall_s1), .Except_s1w(Except_s1w),
        .Commit_s1e(Commit_s1e), .Squash_s1e(Squash_s1e),
        .AWrValid_w(AWrValid_w), .ABoost_w(ABoost_w), .AWrIdx_w(AWrIdx_w),
        .BWrValid_w(BWrValid_w), .BBoost_w(BBoost_w), .BWrIdx_w(BWrIdx_w),
        .ASeqPtr_v1e(ASeqPtr_v1e), .BSeqPtr_v1e(BSeqPtr_v1e),
        .RdIdx0_r(RdIdx0_r), .RdIdx1_r(RdIdx1_r), .RdBoost0_r(RdBoost0_r), .RdBoost1_r(RdBoost1_r),
        .RdSel0_r(RdSel0_r), .RdSel1_r(RdSel1_r), .BoostCnt(BoostCnt), .BoostAny(BoostAny)
    );

    typedef struct packed {
        logic [3:0] ctl;  // {stall, except, commit, squash}
        logic aV, aB; logic [4:0] aI;
        logic bV, bB; logic [4:0] bI;
        logic [4:0] r0; logic rb0;
        logic [4:0] r1; logic rb1;
        logic eA, eB, e0, e1; logic [5:0] eCnt;
    } vec_t;

    int errors = 0;
    int checks = 0;
    bit mSeq[NREGS];
    bit mVal[NREGS];

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] ctl,
                                input logic aV, input logic aB, input logic [4:0] aI,
                                input logic bV, input logic bB, input logic [4:0] bI,
                                input logic [4:0] r0, input logic rb0,
                                input logic [4:0] r1, input logic rb1,
                                input logic eA, input logic eB, input logic e0, input logic e1,
                                input logic [5:0] eCnt);
        vec_t v;
        v.ctl = ctl; v.aV = aV; v.aB = aB; v.aI = aI; v.bV = bV; v.bB = bB; v.bI = bI;
        v.r0 = r0; v.rb0 = rb0; v.r1 = r1; v.rb1 = rb1;
        v.eA = eA; v.eB = eB; v.e0 = e0; v.e1 = e1; v.eCnt = eCnt;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        {Stall_s1, Except_s1w, Commit_s1e, Squash_s1e} = v.ctl;
        AWrValid_w = v.aV; ABoost_w = v.aB; AWrIdx_w = v.aI;
        BWrValid_w = v.bV; BBoost_w = v.bB; BWrIdx_w = v.bI;
        RdIdx0_r = v.r0; RdBoost0_r = v.rb0; RdIdx1_r = v.r1; RdBoost1_r = v.rb1;
    endtask

    function automatic int modelCount();
        int n = 0;
        for (int i = 0; i < NREGS; i++) n += int'(mVal[i]);
        return n;
    endfunction

    task automatic modelReset();
        for (int i = 0; i < NREGS; i++) begin mSeq[i] = 0; mVal[i] = 0; end
    endtask

    // Spec rules applied directly: squash/exception discard, commit flips owners of boosted data.
    task automatic modelUpdate(input vec_t v);
        bit stall, exc, cmt, sqh, sq, cm, hit;
        {stall, exc, cmt, sqh} = v.ctl;
        sq = (sqh && !stall) || exc;
        cm = cmt && !stall && !exc && !sq;
        for (int r = 0; r < NREGS; r++) begin
            hit = (v.aV && v.aB && v.aI == r) || (v.bV && v.bB && v.bI == r);
            if (sq) mVal[r] = 0;
            else if (cm) begin
                if (mVal[r] || hit) mSeq[r] = !mSeq[r];
                mVal[r] = 0;
            end else if (hit) mVal[r] = 1;
        end
    endtask

    // One cycle under model control: drive, compare at negedge, advance model at posedge.
    task automatic step(input vec_t v, input string tag);
        drive(v);
        @(negedge Phi1);
        chk({tag, ".ASeqPtr"}, 8'(ASeqPtr_v1e), 8'(mSeq[v.aI]));
        chk({tag, ".BSeqPtr"}, 8'(BSeqPtr_v1e), 8'(mSeq[v.bI]));
        chk({tag, ".RdSel0"}, 8'(RdSel0_r), 8'(mSeq[v.r0] ^ (v.rb0 & mVal[v.r0])));
        chk({tag, ".RdSel1"}, 8'(RdSel1_r), 8'(mSeq[v.r1] ^ (v.rb1 & mVal[v.r1])));
        chk({tag, ".BoostCnt"}, 8'(BoostCnt), 8'(modelCount()));
        chk({tag, ".BoostAny"}, 8'(BoostAny), 8'(modelCount() != 0));
        @(posedge Phi1);
        modelUpdate(v);
        #1;
    endtask

    task automatic doReset();
        drive('0);
        Reset_b = 1'b0;
        modelReset();
        @(negedge Phi1);
        @(negedge Phi1);
        #1 Reset_b = 1'b1;
        @(posedge Phi1);
        #1;
    endtask

    vec_t tbl[25];
    vec_t v;

    initial begin
        Reset_b = 1'b0;
        drive('0);
        #3;
        chk("reset.BoostCnt", 8'(BoostCnt), 8'd0);
        chk("reset.BoostAny", 8'(BoostAny), 8'd0);
        chk("reset.RdSel0", 8'(RdSel0_r), 8'd0);
        chk("reset.ASeqPtr", 8'(ASeqPtr_v1e), 8'd0);
        doReset();

        //          ctl      aV aB aI   bV bB bI   r0 rb0 r1 rb1  eA eB e0 e1 cnt
        tbl[0]  = mk(4'b0000, 1, 1, 5,  0, 0, 0,  5, 1,  0, 0,   0, 0, 0, 0, 0);
        tbl[1]  = mk(4'b0000, 0, 0, 0,  0, 0, 0,  5, 1,  5, 0,   0, 0, 1, 0, 1);
        tbl[2]  = mk(4'b0000, 1, 1, 3,  1, 1, 7,  5, 1,  0, 0,   0, 0, 1, 0, 1);
        tbl[3]  = mk(4'b0010, 0, 0, 3,  0, 0, 7,  3, 0,  3, 1,   0, 0, 0, 1, 3);
        tbl[4]  = mk(4'b0000, 0, 0, 3,  0, 0, 7,  5, 1,  9, 0,   1, 1, 1, 0, 0);
        tbl[5]  = mk(4'b0000, 1, 1, 9,  0, 0, 0,  9, 1,  0, 0,   0, 0, 0, 0, 0);
        tbl[6]  = mk(4'b0001, 0, 0, 9,  1, 1, 2,  9, 1,  2, 1,   0, 0, 1, 0, 1);
        tbl[7]  = mk(4'b0000, 0, 0, 9,  0, 0, 2,  9, 1,  2, 1,   0, 0, 0, 0, 0);
        tbl[8]  = mk(4'b0000, 1, 1, 6,  0, 0, 0,  6, 1,  0, 0,   0, 0, 0, 0, 0);
        tbl[9]  = mk(4'b1010, 0, 0, 6,  0, 0, 0,  6, 1,  0, 0,   0, 0, 1, 0, 1);
        tbl[10] = mk(4'b0000, 0, 0, 6,  0, 0, 0,  6, 0,  6, 1,   0, 0, 0, 1, 1);
        tbl[11] = mk(4'b0010, 1, 1, 4,  0, 0, 6,  4, 1,  6, 1,   0, 0, 0, 1, 1);
        tbl[12] = mk(4'b0000, 0, 0, 4,  0, 0, 6,  4, 1,  6, 1,   1, 1, 1, 1, 0);
        tbl[13] = mk(4'b0000, 1, 1, 10, 0, 0, 0,  10, 1, 0, 0,   0, 0, 0, 0, 0);
        tbl[14] = mk(4'b0011, 0, 0, 10, 0, 0, 0,  10, 1, 0, 0,   0, 0, 1, 0, 1);
        tbl[15] = mk(4'b0000, 0, 0, 10, 0, 0, 0,  10, 1, 3, 1,   0, 0, 0, 1, 0);
        tbl[16] = mk(4'b0000, 1, 0, 11, 0, 1, 12, 11, 0, 12, 1,  0, 0, 0, 0, 0);
        tbl[17] = mk(4'b0000, 0, 0, 11, 0, 0, 12, 11, 1, 12, 1,  0, 0, 0, 0, 0);
        tbl[18] = mk(4'b0000, 1, 1, 13, 0, 0, 0,  13, 1, 0, 0,   0, 0, 0, 0, 0);
        tbl[19] = mk(4'b1100, 0, 0, 13, 0, 0, 0,  13, 1, 0, 0,   0, 0, 1, 0, 1);
        tbl[20] = mk(4'b0000, 0, 0, 13, 0, 0, 0,  13, 1, 7, 0,   0, 0, 0, 1, 0);
        tbl[21] = mk(4'b0000, 1, 1, 14, 1, 1, 14, 14, 1, 0, 0,   0, 0, 0, 0, 0);
        tbl[22] = mk(4'b0000, 0, 0, 14, 0, 0, 14, 14, 1, 0, 0,   0, 0, 1, 0, 1);
        tbl[23] = mk(4'b0000, 1, 1, 14, 0, 0, 0,  14, 1, 0, 0,   0, 0, 1, 0, 1);
        tbl[24] = mk(4'b0000, 0, 0, 14, 0, 0, 0,  14, 1, 0, 0,   0, 0, 1, 0, 1);

        for (int i = 0; i < 25; i++) begin
            drive(tbl[i]);
            @(negedge Phi1);
            chk($sformatf("vec%0d.ASeqPtr", i), 8'(ASeqPtr_v1e), 8'(tbl[i].eA));
            chk($sformatf("vec%0d.BSeqPtr", i), 8'(BSeqPtr_v1e), 8'(tbl[i].eB));
            chk($sformatf("vec%0d.RdSel0", i), 8'(RdSel0_r), 8'(tbl[i].e0));
            chk($sformatf("vec%0d.RdSel1", i), 8'(RdSel1_r), 8'(tbl[i].e1));
            chk($sformatf("vec%0d.BoostCnt", i), 8'(BoostCnt), 8'(tbl[i].eCnt));
            chk($sformatf("vec%0d.BoostAny", i), 8'(BoostAny), 8'(tbl[i].eCnt != 0));
            @(posedge Phi1);
            #1;
        end

        // Fill all registers, A and B colliding on reg 0, then exception beats commit.
        doReset();
        step(mk(4'b0000, 1, 1, 0, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0), "full.same");
        for (int i = 0; i < NREGS / 2; i++)
            step(mk(4'b0000, 1, 1, 5'(2 * i), 1, 1, 5'(2 * i + 1), 5'(i), 1, 0, 0,
                    0, 0, 0, 0, 0), "full.fill");
        step(mk(4'b0000, 1, 1, 5, 0, 0, 0, 31, 1, 0, 1, 0, 0, 0, 0, 0), "full.rep");
        chk("full.BoostCnt32", 8'(BoostCnt), 8'd32);
        chk("full.BoostAny", 8'(BoostAny), 8'd1);
        step(mk(4'b0110, 0, 0, 0, 0, 0, 0, 31, 1, 0, 1, 0, 0, 0, 0, 0), "full.exc");
        chk("full.postExcCnt", 8'(BoostCnt), 8'd0);
        chk("full.postExcSeq", 8'(ASeqPtr_v1e), 8'd0);
        step('0, "full.idle");

        // Randomized traffic against the reference model.
        doReset();
        for (int n = 0; n < 600; n++) begin
            v = '0;
            v.ctl[3] = ($urandom_range(0, 3) == 0);
            v.ctl[2] = ($urandom_range(0, 24) == 0);
            v.ctl[1] = ($urandom_range(0, 7) == 0);
            v.ctl[0] = ($urandom_range(0, 11) == 0);
            v.aV = $urandom_range(0, 1); v.aB = ($urandom_range(0, 3) != 0); v.aI = 5'($urandom);
            v.bV = $urandom_range(0, 1); v.bB = ($urandom_range(0, 3) != 0); v.bI = 5'($urandom);
            if ($urandom_range(0, 9) == 0) v.bI = v.aI;
            v.r0 = 5'($urandom); v.rb0 = $urandom_range(0, 1);
            v.r1 = 5'($urandom); v.rb1 = $urandom_range(0, 1);
            step(v, "rand");
        end

        // Asynchronous reset in the middle of a cycle with live state.
        doReset();
        step(mk(4'b0000, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "ar.b1");
        step(mk(4'b0010, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "ar.cm");
        step(mk(4'b0000, 1, 1, 2, 1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0), "ar.w0");
        step(mk(4'b0000, 1, 1, 4, 1, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0), "ar.w1");
        step(mk(4'b0000, 1, 1, 6, 1, 1, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0), "ar.w2");
        drive(mk(4'b0000, 0, 0, 1, 0, 0, 2, 1, 1, 2, 1, 0, 0, 0, 0, 0));
        #1;
        chk("ar.preCnt", 8'(BoostCnt), 8'd6);
        chk("ar.preSeq1", 8'(ASeqPtr_v1e), 8'd1);
        #1 Reset_b = 1'b0;
        #1;
        chk("ar.ASeqPtr", 8'(ASeqPtr_v1e), 8'd0);
        chk("ar.RdSel0", 8'(RdSel0_r), 8'd0);
        chk("ar.RdSel1", 8'(RdSel1_r), 8'd0);
        chk("ar.BoostCnt", 8'(BoostCnt), 8'd0);
        chk("ar.BoostAny", 8'(BoostAny), 8'd0);
        modelReset();
        @(negedge Phi1);
        #1 Reset_b = 1'b1;
        @(posedge Phi1);
        #1;
        step('0, "ar.after");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
